seq_demux_writer: RTL

//  Writing end of the memory-game sequence path: the mux selects one stored value out; this block routes one input in.

---
 rtl/seq_demux_writer_pkg.sv | 15 +
 rtl/seq_demux_writer_demux_1xn.sv | 18 +
 rtl/seq_demux_writer.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_demux_writer_pkg.sv
// Game-wide defaults for the memory-game sequence path: play width, slot count and button codes.
package seq_demux_writer_pkg;

    localparam int unsigned PLAY_WIDTH = 4;
    localparam int unsigned SLOT_DEPTH = 16;
    localparam int unsigned SLOT_AW    = $clog2(SLOT_DEPTH);

    typedef enum logic [PLAY_WIDTH-1:0] {
        BtnGreen  = 4'b0001,
        BtnRed    = 4'b0010,
        BtnYellow = 4'b0100,
        BtnBlue   = 4'b1000
    } button_e;

endpackage

// File: rtl/seq_demux_writer_demux_1xn.sv
// Address-plus-enable to one-hot slot write-enable decoder.
module demux_1xn #(
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic [AW-1:0]    addr,
    input  logic             en,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_demux_writer.sv
// Writes one play per valid/ready handshake into the next slot of an N-slot bank;
// the bank is read back combinationally through rd_addr.
module seq_demux_writer
    import seq_demux_writer_pkg::*;
#(
    parameter int unsigned WIDTH = PLAY_WIDTH,
    parameter int unsigned DEPTH = SLOT_DEPTH,
    parameter int unsigned AW    = SLOT_AW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] data_out,
    output logic [AW:0]      count,
    output logic             full,
    output logic             wr_done,
    output logic             bad_code
);

    localparam logic [AW:0]      LastCount = (AW+1)'(DEPTH - 1);
    localparam logic [WIDTH-1:0] OneCode   = WIDTH'(1);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             full_q;
    logic             wr_done_q;
    logic             bad_code_q;
    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [DEPTH-1:0] slot_we;
    logic             accept;
    logic             write_en;
    logic             code_onehot;

    // in_ready depends only on registered state, so there is no path from in_valid.
    assign in_ready    = ~full_q;
    assign accept      = in_valid & in_ready;
    assign write_en    = accept & ~clear;
    assign code_onehot = (data_in != '0) && ((data_in & (data_in - OneCode)) == '0);

    demux_1xn #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_demux (
        .addr   (wr_ptr_q),
        .en     (write_en),
        .onehot (slot_we)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            wr_done_q  <= 1'b0;
            bad_code_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            wr_done_q  <= 1'b0;
            bad_code_q <= 1'b0;
        end else begin
            wr_done_q <= accept;
            if (accept) begin
                // Pointer wraps naturally to 0 on the write that fills the bank.
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 1'b1;
                full_q   <= (count_q == LastCount);
                if (!code_onehot) begin
                    bad_code_q <= 1'b1;
                end
            end
        end
    end

    // Clear leaves the slot contents alone; only reset zeroes them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (slot_we[i]) begin
                    slot_q[i] <= data_in;
                end
            end
        end
    end

    assign data_out = slot_q[rd_addr];
    assign count    = count_q;
    assign full     = full_q;
    assign wr_done  = wr_done_q;
    assign bad_code = bad_code_q;

endmodule
